// File: rtl/ddr_rpath.sv
// DDR read data-path: dual-edge capture, rise/fall pairing, sample-gated burst tagging
// and a show-ahead FIFO drained by the Wishbone-side read logic.
module ddr_rpath #(
  parameter int DQ_WIDTH     = 16,
  parameter int SAMPLE_DELAY = 2,
  parameter int BURST_WORDS  = 2,
  parameter int FIFO_AW      = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample,
  input  logic [DQ_WIDTH-1:0]     ddr_dq,
  output logic [2*DQ_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [FIFO_AW:0]        rd_level,
  output logic                    overflow,
  output logic                    short_burst,
  input  logic                    clr_err
);

  localparam int              LP_DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LP_FULL    = (FIFO_AW+1)'(LP_DEPTH);
  localparam logic [2:0]      LP_LAST_IDX = 3'(BURST_WORDS - 1);
  localparam bit              LP_SINGLE   = (BURST_WORDS == 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  logic [DQ_WIDTH-1:0]    r_rise_q;
  logic [DQ_WIDTH-1:0]    r_fall_q;
  logic [2*DQ_WIDTH-1:0]  r_pair_q;
  logic [SAMPLE_DELAY-1:0] r_sample_chain;
  state_t                 r_state;
  logic [2:0]             r_beat_cnt;
  logic [2*DQ_WIDTH:0]    r_mem [LP_DEPTH];
  logic [FIFO_AW:0]       r_wptr;
  logic [FIFO_AW:0]       r_rptr;
  logic                   r_overflow;
  logic                   r_short_burst;

  logic                   w_push;
  logic                   w_tag_last;
  logic                   w_short_set;
  logic [FIFO_AW:0]       w_level;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_wr;
  logic                   w_ovf_set;
  logic [2*DQ_WIDTH:0]    w_head;

  // Capture registers carry no reset: their contents only matter once a gated push uses them.
  always_ff @(posedge clk) begin
    r_rise_q <= ddr_dq;
    r_pair_q <= {r_fall_q, r_rise_q};
  end

  always_ff @(negedge clk) begin
    r_fall_q <= ddr_dq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sample_chain <= '0;
    end else begin
      r_sample_chain[0] <= sample;
      for (int i = 1; i < SAMPLE_DELAY; i++) begin
        r_sample_chain[i] <= r_sample_chain[i-1];
      end
    end
  end

  assign w_push      = r_sample_chain[SAMPLE_DELAY-1];
  assign w_tag_last  = (r_state == S_IDLE) ? LP_SINGLE : (r_beat_cnt == LP_LAST_IDX);
  assign w_short_set = (r_state == S_BURST) && !w_push;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_beat_cnt <= 3'd1;
            if (!LP_SINGLE) r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_push) begin
            if (r_beat_cnt == LP_LAST_IDX) r_state <= S_IDLE;
            else                           r_beat_cnt <= r_beat_cnt + 3'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Full with a same-cycle pop still accepts the push: the slot being written is the head leaving.
  assign w_level   = r_wptr - r_rptr;
  assign w_full    = (w_level == LP_FULL);
  assign w_empty   = (w_level == '0);
  assign w_pop     = !w_empty && rd_ready;
  assign w_wr      = w_push && (!w_full || w_pop) && !reset;
  assign w_ovf_set = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[FIFO_AW-1:0]] <= {w_tag_last, r_pair_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow    <= 1'b0;
      r_short_burst <= 1'b0;
    end else begin
      if (w_ovf_set)    r_overflow <= 1'b1;
      else if (clr_err) r_overflow <= 1'b0;
      if (w_short_set)  r_short_burst <= 1'b1;
      else if (clr_err) r_short_burst <= 1'b0;
    end
  end

  assign w_head      = r_mem[r_rptr[FIFO_AW-1:0]];
  assign rd_data     = w_head[2*DQ_WIDTH-1:0];
  assign rd_last     = w_head[2*DQ_WIDTH];
  assign rd_valid    = !w_empty;
  assign rd_level    = w_level;
  assign overflow    = r_overflow;
  assign short_burst = r_short_burst;

endmodule
